// File: rtl/conv_encoder_k7.sv
// ---------------------------------------------------------------------------
// conv_encoder_k7
//   Rate-1/2, constraint-length-7 feedforward convolutional encoder with
//   generators g0 = 171 (octal) and g1 = 133 (octal). Accepts one
//   information bit per cycle and produces one coded pair {g0,g1} per cycle
//   through a single output register.
//
//   Optional feature macro: CONV_ENC_TAIL_EN
//     defined   : zero-tail termination. After the in_last bit, six pairs with
//                 u=0 are generated (TAIL state) to flush the shift register.
//                 The sixth tail pair carries out_last. N bits -> N+6 pairs.
//     undefined : the pair for the in_last bit carries out_last and the shift
//                 register is cleared directly. N bits -> N pairs.
//
// Ports
//   clk          in   1  clock, all state on rising edge
//   rst_n        in   1  asynchronous active-low reset
//   in_valid     in   1  in_bit/in_last valid
//   in_ready     out  1  encoder accepts input this cycle
//   in_bit       in   1  information bit
//   in_last      in   1  final information bit of frame
//   out_valid    out  1  out_pair/out_last valid
//   out_ready    in   1  downstream accepts pair
//   out_pair     out  2  coded pair {g0,g1}
//   out_last     out  1  final coded pair of frame
//   o_dbg_state  out  1  FSM state (0 = RUN, 1 = TAIL)
//
// Handshake: on both sides a transfer happens on a rising edge where
//   valid & ready are both high. The output side holds out_pair/out_last
//   stable while out_valid & ~out_ready; in_ready never depends on in_valid.
// ---------------------------------------------------------------------------
module conv_encoder_k7 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_bit,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] out_pair,
    output logic       out_last,
    output logic       o_dbg_state
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_TAIL = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [5:0] r_sr;          // r_sr[0] = most recent past bit
    logic [5:0] w_sr_nxt;
    logic [2:0] r_cnt;         // tail pairs still to generate
    logic [2:0] w_cnt_nxt;
    logic       r_out_valid;
    logic       w_out_valid_nxt;
    logic [1:0] r_out_pair;
    logic [1:0] w_out_pair_nxt;
    logic       r_out_last;
    logic       w_out_last_nxt;

    logic       w_slot_free;
    logic       w_accept;
    logic       w_u;
    logic       w_g0;
    logic       w_g1;

    // The output register can take a new pair when it is empty or is being
    // drained in this same cycle.
    assign w_slot_free = ~r_out_valid | out_ready;

    // rst_n gates in_ready so nothing is offered as accepted while in reset.
    assign in_ready = rst_n & (r_state == ST_RUN) & w_slot_free;
    assign w_accept = in_valid & in_ready;

    // Tail pairs are generated with a zero input bit.
    assign w_u  = (r_state == ST_RUN) ? in_bit : 1'b0;
    assign w_g0 = w_u ^ r_sr[0] ^ r_sr[1] ^ r_sr[2] ^ r_sr[5];
    assign w_g1 = w_u ^ r_sr[1] ^ r_sr[2] ^ r_sr[4] ^ r_sr[5];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_sr        <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_pair  <= 2'b00;
            r_out_last  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sr        <= w_sr_nxt;
            r_cnt       <= w_cnt_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_pair  <= w_out_pair_nxt;
            r_out_last  <= w_out_last_nxt;
        end
    end

    // Next-state and datapath
    always_comb begin
        w_state_nxt     = r_state;
        w_sr_nxt        = r_sr;
        w_cnt_nxt       = r_cnt;
        // A held pair is dropped once taken; a stalled one stays put.
        w_out_valid_nxt = r_out_valid & ~out_ready;
        w_out_pair_nxt  = r_out_pair;
        w_out_last_nxt  = r_out_last;

        case (r_state)
            ST_RUN: begin
                if (w_accept) begin
                    w_out_valid_nxt = 1'b1;
                    w_out_pair_nxt  = {w_g0, w_g1};
                    w_out_last_nxt  = 1'b0;
                    w_sr_nxt        = {r_sr[4:0], w_u};
                    if (in_last) begin
`ifdef CONV_ENC_TAIL_EN
                        w_state_nxt = ST_TAIL;
                        w_cnt_nxt   = 3'd6;
`else
                        // Direct termination: next frame starts from zero.
                        w_out_last_nxt = 1'b1;
                        w_sr_nxt       = '0;
`endif
                    end
                end
            end
            ST_TAIL: begin
                // Only reachable when zero-tail termination is built in.
                if (w_slot_free) begin
                    w_out_valid_nxt = 1'b1;
                    w_out_pair_nxt  = {w_g0, w_g1};
                    w_out_last_nxt  = (r_cnt == 3'd1);
                    w_sr_nxt        = {r_sr[4:0], 1'b0};
                    w_cnt_nxt       = r_cnt - 3'd1;
                    if (r_cnt == 3'd1) begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    assign out_valid   = r_out_valid;
    assign out_pair    = r_out_pair;
    assign out_last    = r_out_last;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_conv_encoder_k7.sv
// ---------------------------------------------------------------------------
// tb_conv_encoder_k7
//   Self-checking bench for conv_encoder_k7. Expected pairs are pushed into
//   exp_q when a frame is issued; a monitor pops and compares on every output
//   handshake. The reference model computes each pair as the parity of the
//   generator polynomial against the frame's bit history.
//   Follows the DUT build: define CONV_ENC_TAIL_EN for zero-tail termination.
// ---------------------------------------------------------------------------
module tb_conv_encoder_k7;

    // -------------------------------------------------------------- clock/reset
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic       in_bit;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_pair;
    logic       out_last;
    logic       dbg_state;

    always #5 clk = ~clk;

    conv_encoder_k7 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_bit      (in_bit),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pair    (out_pair),
        .out_last    (out_last),
        .o_dbg_state (dbg_state)
    );

    // -------------------------------------------------------------- scoreboard
    logic [2:0] exp_q[$];      // {last, g0, g1}
    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_pops  = 0;
    int         rdy_mode = 0;  // 0: always 1, 1: 1,0,0 pattern, 2: random
    int         rdy_phase = 0;
    logic       frame_bits [0:63];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: pair at time t is the parity of generator & history.
    task automatic push_model(input int n);
        logic       seq[$];
        logic [6:0] gp0;
        logic [6:0] gp1;
        logic       a;
        logic       b;
        gp0 = 7'o171;
        gp1 = 7'o133;
        for (int i = 0; i < n; i++) seq.push_back(frame_bits[i]);
`ifdef CONV_ENC_TAIL_EN
        for (int i = 0; i < 6; i++) seq.push_back(1'b0);
`endif
        for (int t = 0; t < seq.size(); t++) begin
            a = 1'b0;
            b = 1'b0;
            for (int d = 0; d < 7; d++) begin
                if (t - d >= 0) begin
                    a = a ^ (gp0[6-d] & seq[t-d]);
                    b = b ^ (gp1[6-d] & seq[t-d]);
                end
            end
            exp_q.push_back({(t == seq.size() - 1), a, b});
        end
    endtask

    task automatic push_impulse();
`ifdef CONV_ENC_TAIL_EN
        exp_q.push_back(3'b011);
        exp_q.push_back(3'b010);
        exp_q.push_back(3'b011);
        exp_q.push_back(3'b011);
        exp_q.push_back(3'b000);
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b111);
`else
        exp_q.push_back(3'b111);
`endif
    endtask

    // Monitor: compare on each output handshake, check stability while stalled.
    logic       stall_prev = 1'b0;
    logic [2:0] stall_val  = 3'b000;
    logic [2:0] popped;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_hold", {out_valid, out_last, out_pair}, {1'b1, stall_val});
            end
            if (out_valid && out_ready) begin
                n_pops++;
                if (exp_q.size() == 0) begin
                    check("unexpected_pair", {out_last, out_pair}, 32'hDEAD);
                end else begin
                    popped = exp_q.pop_front();
                    check("pair", {out_last, out_pair}, popped);
                end
            end
            stall_prev = out_valid & ~out_ready;
            stall_val  = {out_last, out_pair};
        end
    end

    // Downstream ready driver
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: begin
                out_ready = (rdy_phase % 3 == 0);
                rdy_phase++;
            end
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // -------------------------------------------------------------- driver tasks
    task automatic drive_bit(input logic b, input logic l);
        logic ok;
        int   c;
        ok = 1'b0;
        c  = 0;
        in_valid = 1'b1;
        in_bit   = b;
        in_last  = l;
        while (!ok && c < 300) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            c++;
        end
        if (!ok) check("in_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_bit   = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input int n, input bit gaps);
        for (int i = 0; i < n; i++) frame_bits[i] = 1'($urandom_range(0, 1));
        push_model(n);
        for (int i = 0; i < n; i++) begin
            drive_bit(frame_bits[i], (i == n - 1));
            if (gaps) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic drain(input string name);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 2000) begin
            @(posedge clk);
            c++;
        end
        @(posedge clk);
        #2;
        check(name, exp_q.size(), 0);
        check({name, "_no_extra"}, out_valid, 0);
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_pair", {out_last, out_pair}, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_idle", out_valid, 0);
        end
        @(posedge clk);
        #1;
    endtask

    // -------------------------------------------------------------- main
    int consec;
    int total_pairs;
    int wcnt;

    initial begin : main
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        rdy_mode  = 0;
        #12;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_pair", out_pair, 0);
        check("reset_out_last", out_last, 0);
        check("reset_in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_in_ready", in_ready, 1);

        // Impulse with out_ready high: pairs on consecutive cycles.
        push_impulse();
        drive_bit(1'b1, 1'b1);
`ifdef CONV_ENC_TAIL_EN
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            check("impulse_valid", out_valid, 1);
            check("impulse_in_ready", in_ready, (k == 6));
        end
`else
        @(negedge clk);
        check("impulse_valid", out_valid, 1);
        check("impulse_in_ready", in_ready, 1);
`endif
        drain("impulse");

`ifdef CONV_ENC_TAIL_EN
        // All-zero 8-bit frame: 14 zero pairs, in_ready low across the tail.
        for (int i = 0; i < 13; i++) exp_q.push_back(3'b000);
        exp_q.push_back(3'b100);
        for (int i = 0; i < 8; i++) drive_bit(1'b0, (i == 7));
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            check("zero_tail_in_ready", in_ready, (k == 6));
        end
        drain("zero_frame");
`else
        // Two-bit frame 1,1 then single-bit frame 1.
        exp_q.push_back(3'b011);
        exp_q.push_back(3'b101);
        exp_q.push_back(3'b111);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b1, 1'b1);
        drive_bit(1'b1, 1'b1);
        drain("direct_term");
`endif

        // Backpressure 1,0,0,... on the impulse frame.
        rdy_mode  = 1;
        rdy_phase = 0;
        push_impulse();
        drive_bit(1'b1, 1'b1);
        drain("impulse_bp");
        rdy_mode = 0;
        @(posedge clk);
        #1;

`ifdef CONV_ENC_TAIL_EN
        // Reset after the third tail pair has been taken.
        push_impulse();
        n_pops = 0;
        drive_bit(1'b1, 1'b1);
        wcnt = 0;
        while (n_pops < 4 && wcnt < 50) begin
            @(posedge clk);
            wcnt++;
        end
        check("mid_tail_reached", (n_pops >= 4), 1);
        check("mid_tail_state", dbg_state, 1);
        do_reset();
        push_impulse();
        drive_bit(1'b1, 1'b1);
        drain("after_tail_reset");
`endif

        // Reset in the middle of a frame.
        exp_q.push_back(3'b011);
        drive_bit(1'b1, 1'b0);
        drain("mid_frame_pair");
        do_reset();
        push_impulse();
        drive_bit(1'b1, 1'b1);
        drain("after_frame_reset");

        // Back-to-back frames with out_ready high: no bubble at frame boundary.
        rdy_mode = 0;
`ifdef CONV_ENC_TAIL_EN
        total_pairs = 17;
`else
        total_pairs = 5;
`endif
        fork
            begin
                send_frame(3, 1'b0);
                send_frame(2, 1'b0);
            end
            begin
                consec = 0;
                wcnt   = 0;
                while (!out_valid && wcnt < 50) begin
                    @(negedge clk);
                    wcnt++;
                end
                while (out_valid && consec < 100) begin
                    consec++;
                    @(negedge clk);
                end
            end
        join
        check("throughput_consec", consec, total_pairs);
        drain("throughput");

        // Randomized frames under varied backpressure.
        for (int f = 0; f < 14; f++) begin
            rdy_mode = $urandom_range(0, 2);
            send_frame($urandom_range(1, 24), 1'($urandom_range(0, 1)));
        end
        drain("random_frames");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL global_timeout: got running expected finished");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/conv_encoder_k7.md
CONV_ENCODER_K7 -- requirements
Module: conv_encoder_k7

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state on its rising edge.
REQ-002 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have port: in_valid  input  1  in_bit/in_last valid.
REQ-004 SHALL have port: in_ready  output  1  encoder accepts input this cycle.
REQ-005 SHALL have port: in_bit  input  1  information bit.
REQ-006 SHALL have port: in_last  input  1  final information bit of frame.
REQ-007 SHALL have port: out_valid  output  1  out_pair/out_last valid.
REQ-008 SHALL have port: out_ready  input  1  downstream (channel/BMC side) accepts pair.
REQ-009 SHALL have port: out_pair  output  2  coded pair {g0,g1}, same ordering as the decoder's rx_pair.
REQ-010 SHALL have port: out_last  output  1  final coded pair of frame.

Function
REQ-011 SHALL implement rate-1/2, K=7 feedforward convolutional code; generators g0=171 octal, g1=133 octal.
REQ-012 SHALL hold 6-bit shift register s[0..5], s[0] most recent past bit; u = current input bit.
REQ-013 SHALL compute g0 = u^s0^s1^s2^s5 and g1 = u^s1^s2^s4^s5.
REQ-014 SHALL update state on each generated pair: s <= {u, s[0..4]} (s[5] dropped).
REQ-015 SHALL use one output register; a pair is generated only when the register is empty or out_ready=1 in the same cycle.
REQ-016 SHALL assert in_ready = (state==RUN) & (~out_valid | out_ready).
REQ-017 SHALL accept input on in_valid & in_ready; the coded pair appears on out_pair with out_valid=1 the next cycle (latency 1).
REQ-018 SHALL hold out_pair/out_last stable while out_valid & ~out_ready.
REQ-019 SHALL clear out_valid after handshake when no new pair is generated that cycle.
REQ-020 SHALL implement FSM with states RUN and TAIL plus 3-bit tail counter.
REQ-021 RUN: accepted in_last=1 -> TAIL, counter=6 (TAIL_EN) or stay RUN (no TAIL_EN).
REQ-022 TAIL: in_ready=0; each free output slot generates a pair with u=0 and decrements counter; the pair generated with counter=1 carries out_last=1; then -> RUN.
REQ-023 SHALL guarantee s==0 when a frame's out_last pair is generated (tail flush or direct clear).
REQ-024 SHALL sustain one pair per cycle with out_ready held high, including the RUN->TAIL->RUN boundary (next frame's first bit accepted the cycle after the last tail pair is generated).

Reset
REQ-025 SHALL on rst_n=0 immediately force: state=RUN, s=0, counter=0, out_valid=0, out_pair=2'b00, out_last=0; in_ready=0 during reset.
REQ-026 SHALL abandon any frame in progress (including mid-TAIL) on reset; no residual pairs emitted after release.

Configuration
REQ-027 SHALL use macro CONV_ENC_TAIL_EN.
REQ-028 With CONV_ENC_TAIL_EN defined: zero-tail termination per REQ-021/022; frame of N bits yields N+6 pairs.
REQ-029 Without CONV_ENC_TAIL_EN: no TAIL state; pair for in_last bit carries out_last=1 and s is cleared to 0 after it; frame of N bits yields N pairs.

Verification
REQ-030 Impulse, TAIL_EN, out_ready=1: single bit 1 with in_last=1 -> pairs 11,10,11,11,00,01,11 on consecutive cycles, out_last only on 7th.
REQ-031 All-zero frame of 8 bits, TAIL_EN -> 14 pairs of 00, out_last on 14th; in_ready=0 during 6 tail cycles.
REQ-032 Backpressure: impulse frame, out_ready toggled 1,0,0,1,... -> same 7-pair sequence, out_pair stable while stalled, no pair lost or duplicated.
REQ-033 Reset asserted after 3rd tail pair -> out_valid=0 immediately; after release, bit 1 with in_last -> first pair 11 (s was cleared).
REQ-034 No TAIL_EN: frame bits 1,1 (last on 2nd) -> pairs 11,01 with out_last on 2nd; following frame bit 1 -> 11 (state cleared).
REQ-035 Loopback: random 200-bit frames, TAIL_EN, out_pair fed to the team's K=7 Viterbi decoder -> decoded bits equal input bits.
